// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Main-memory responder sitting on the slave side of the CPU/cache memory
// request interface. It accepts single-word writes, single-word reads and
// BURST_BEATS-word cache-line burst reads. Read data comes back LATENCY cycles
// after the request is accepted, one beat per cycle, with no gaps and no
// back-pressure.
//
// Build option:
//   CRIT_WORD_FIRST_EN  when defined, a burst starts at the requested word and
//                       wraps within the line; otherwise it starts at the
//                       line base. Single reads and writes are unaffected.
//
// Parameters:
//   LATENCY      cycles from request accept to first response beat (1..15)
//   MEM_WORDS    number of 16-bit words stored (index = addr[15:1] mod MEM_WORDS)
//   BURST_BEATS  words per burst read, power of two
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset (storage is not cleared)
//   req_en     request valid
//   req_wr     1 = write, 0 = read
//   req_burst  reads only: 1 = line burst, 0 = single word
//   req_addr   byte address, bit 0 ignored
//   req_wdata  write data
//   req_ready  responder can accept a request this cycle
//   rsp_valid  rsp_data / rsp_addr hold a valid beat
//   rsp_last   final beat of the current read
//   rsp_data   read data
//   rsp_addr   byte address of the current beat, bit 0 always 0
// -----------------------------------------------------------------------------
module mem_line_responder #(
    parameter int LATENCY     = 4,
    parameter int MEM_WORDS   = 32768,
    parameter int BURST_BEATS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic        rsp_last,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr
);

    localparam int OFF_W = $clog2(BURST_BEATS);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [15:1]        base_q, base_d;
    logic               burst_q, burst_d;
    logic [15:0]        rsp_addr_q;
    logic               rsp_last_q, rsp_last_d;
    logic [15:0]        rsp_data_q;

    // High when the coming edge presents a new beat on the response outputs.
    logic               load_beat;

    logic               wr_fire;
    logic               rd_fire;
    logic [15:1]        src_word;
    logic               src_burst;
    logic [OFF_W-1:0]   start_off;
    logic [OFF_W-1:0]   beat_off;
    logic [15:0]        beat_addr;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;

    logic [15:0]        mem_q [0:MEM_WORDS-1];

    logic               unused_bits;
    assign unused_bits = req_addr[0];

    function automatic logic [IDX_W-1:0] word_idx(input logic [15:1] w);
        word_idx = IDX_W'(32'(w) % MEM_WORDS);
    endfunction

    // -------------------------------------------------------------------------
    // Request acceptance
    // -------------------------------------------------------------------------
    assign req_ready = (state_q == S_IDLE);
    assign wr_fire   = req_ready & req_en & req_wr;
    assign rd_fire   = req_ready & req_en & ~req_wr;

    // -------------------------------------------------------------------------
    // Beat address generation.
    // With LATENCY=1 the first beat is loaded on the accept edge itself, before
    // base_q/burst_q are valid, so the request fields are used directly while
    // idle and the latched copies afterwards.
    // -------------------------------------------------------------------------
    assign src_word  = req_ready ? req_addr[15:1] : base_q;
    assign src_burst = req_ready ? req_burst      : burst_q;

`ifdef CRIT_WORD_FIRST_EN
    assign start_off = src_word[OFF_W:1];
`else
    assign start_off = '0;
`endif

    // Offset arithmetic is OFF_W bits wide, so it wraps inside the line and
    // never carries into the line address.
    assign beat_off  = start_off + beat_d;
    assign beat_addr = src_burst ? {src_word[15:OFF_W+1], beat_off, 1'b0}
                                 : {src_word, 1'b0};
    assign rsp_last_d = ~src_burst | (beat_d == OFF_W'(BURST_BEATS - 1));

    assign rd_idx = word_idx(beat_addr[15:1]);
    assign wr_idx = word_idx(req_addr[15:1]);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        base_d    = base_q;
        burst_d   = burst_q;
        load_beat = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_fire) begin
                    base_d  = req_addr[15:1];
                    burst_d = req_burst;
                    beat_d  = '0;
                    if (LATENCY <= 1) begin
                        state_d   = S_XFER;
                        load_beat = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        lat_cnt_d = CNT_W'(LATENCY - 1);
                    end
                end
            end

            S_WAIT: begin
                // The edge that takes the counter to zero is the one that
                // loads the first beat, so the transfer starts exactly
                // LATENCY cycles after accept.
                if (lat_cnt_q <= CNT_W'(1)) begin
                    state_d   = S_XFER;
                    lat_cnt_d = '0;
                    beat_d    = '0;
                    load_beat = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end

            S_XFER: begin
                if (rsp_last_q) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d    = beat_q + OFF_W'(1);
                    load_beat = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            beat_q     <= '0;
            base_q     <= '0;
            burst_q    <= 1'b0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            burst_q   <= burst_d;
            if (load_beat) begin
                rsp_addr_q <= beat_addr;
                rsp_last_q <= rsp_last_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage: write port and registered read port.
    // Writes only happen in IDLE and reads are only launched from WAIT/XFER
    // (or the LATENCY=1 accept edge, which is a read), so the two never
    // target the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            mem_q[wr_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
        end else if (load_beat) begin
            rsp_data_q <= mem_q[rd_idx];
        end
    end

    assign rsp_valid = (state_q == S_XFER);
    assign rsp_last  = (state_q == S_XFER) & rsp_last_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// Testbench for mem_line_responder. Two instances: LATENCY=4 (main tests) and
// LATENCY=1 (direct IDLE->XFER path). Stimulus pushes expected beats into a
// per-instance queue; a monitor pops and compares whenever rsp_valid is high.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en    [2];
    logic        wr    [2];
    logic        bst   [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        ready [2];
    logic        valid [2];
    logic        last  [2];
    logic [15:0] data  [2];
    logic [15:0] raddr [2];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    beat_t       sb0[$];
    beat_t       sb1[$];
    logic [15:0] shadow [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_line_responder #(.LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_en(en[0]), .req_wr(wr[0]), .req_burst(bst[0]),
        .req_addr(addr[0]), .req_wdata(wdata[0]),
        .req_ready(ready[0]), .rsp_valid(valid[0]), .rsp_last(last[0]),
        .rsp_data(data[0]), .rsp_addr(raddr[0])
    );

    mem_line_responder #(.LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_en(en[1]), .req_wr(wr[1]), .req_burst(bst[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]),
        .req_ready(ready[1]), .rsp_valid(valid[1]), .rsp_last(last[1]),
        .rsp_data(data[1]), .rsp_addr(raddr[1])
    );

    function automatic int lat_of(input int id);
        return (id == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic mon(input int id);
        beat_t e;
        if (valid[id] === 1'b1) begin
            if ((id == 0 && sb0.size() == 0) || (id == 1 && sb1.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat dut%0d: got beat addr 0x%04h data 0x%04h, required no beat (cycle %0d)",
                         id, raddr[id], data[id], cyc);
            end else begin
                e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                $display("dut%0d beat cycle %0d addr 0x%04h data 0x%04h last %0d",
                         id, cyc, raddr[id], data[id], last[id]);
                chk("beat_cycle", cyc, e.cyc);
                chk("beat_addr", raddr[id], e.addr);
                chk("beat_data", data[id], e.data);
                chk("beat_last", last[id], e.last);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------------------------------------------------------- drivers
    task automatic do_write(input int id, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        chk("wr_ready", ready[id], 1);
        en[id] = 1'b1; wr[id] = 1'b1; bst[id] = 1'b0; addr[id] = a; wdata[id] = d;
        shadow[id * 65536 + int'(a[15:1])] = d;
        $display("dut%0d write addr 0x%04h data 0x%04h", id, a, d);
        @(negedge clk);
        en[id] = 1'b0; wr[id] = 1'b0;
    endtask

    // Issues a read and queues the first nkeep expected beats.
    task automatic issue_read(input int id, input logic [15:0] a, input logic b,
                              input int nkeep, output int c0);
        beat_t       e;
        logic [2:0]  off;
        logic [15:0] ea;
        int          nb;
        @(negedge clk);
        chk("rd_ready", ready[id], 1);
        en[id] = 1'b1; wr[id] = 1'b0; bst[id] = b; addr[id] = a;
        c0 = cyc;
        nb = b ? 8 : 1;
        $display("dut%0d read addr 0x%04h burst %0d accepted cycle %0d", id, a, b, c0);
        for (int i = 0; i < nb && i < nkeep; i++) begin
            if (!b) begin
                ea = {a[15:1], 1'b0};
            end else begin
`ifdef CRIT_WORD_FIRST_EN
                off = a[3:1] + 3'(i);
`else
                off = 3'(i);
`endif
                ea = {a[15:4], off, 1'b0};
            end
            e.addr = ea;
            e.data = shadow[id * 65536 + int'(ea[15:1])];
            e.last = (i == nb - 1);
            e.cyc  = c0 + lat_of(id) + i;
            if (id == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(negedge clk);
        en[id] = 1'b0;
    endtask

    // req_ready must stay low until the last beat is done, then rise.
    task automatic wait_done(input int id, input int c0, input int nb);
        int done;
        done = c0 + lat_of(id) + nb;
        while (cyc < done) begin
            @(negedge clk);
            chk((cyc >= done) ? "ready_after" : "ready_busy", ready[id], (cyc >= done));
        end
    endtask

    task automatic do_read(input int id, input logic [15:0] a, input logic b);
        int c0;
        issue_read(id, a, b, 8, c0);
        wait_done(id, c0, b ? 8 : 1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int c0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; wr[i] = 1'b0; bst[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", ready[i], 1);
            chk("rst_valid", valid[i], 0);
            chk("rst_last", last[i], 0);
            chk("rst_data", data[i], 0);
            chk("rst_addr", raddr[i], 0);
        end
        rst_n = 1'b1;

        // 1: single write/read with latency and ready timing
        do_write(0, 16'h0010, 16'h1234);
        do_read(0, 16'h0010, 1'b0);

        // 2: aligned burst
        for (int i = 0; i < 8; i++) do_write(0, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i));
        do_read(0, 16'h0020, 1'b1);

        // 3: mid-line burst
        do_read(0, 16'h0026, 1'b1);

        // 4: write during WAIT is ignored
        issue_read(0, 16'h0010, 1'b0, 1, c0);
        @(negedge clk);
        en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hBEEF;
        $display("dut0 write 0x0010 <- 0xBEEF during WAIT (cycle %0d)", cyc);
        @(negedge clk);
        en[0] = 1'b0; wr[0] = 1'b0;
        wait_done(0, c0, 1);
        do_read(0, 16'h0010, 1'b0);

        // 5: reset after beat index 3 of a burst
        issue_read(0, 16'h0020, 1'b1, 4, c0);
        while (cyc < c0 + LAT0 + 3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", valid[0], 0);
        chk("abort_last", last[0], 0);
        chk("abort_ready", ready[0], 1);
        chk("abort_data", data[0], 0);
        rst_n = 1'b1;
        do_read(0, 16'h0022, 1'b0);

        // 6: odd address, and the LATENCY=1 instance
        do_write(0, 16'h0010, 16'h5555);
        do_read(0, 16'h0011, 1'b0);
        do_write(1, 16'h0010, 16'h5555);
        do_read(1, 16'h0011, 1'b0);
        for (int i = 0; i < 8; i++) do_write(1, 16'h0040 + 16'(2 * i), 16'hC000 + 16'(i));
        do_read(1, 16'h0046, 1'b1);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb0.size() + sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
